// File: rtl/ex6_out_monitor.sv
// Run-length encoder and trace FIFO for the ex6 controller's y1..y8 output word.
// Optional legal-output checking is enabled with `define EX6MON_LEGAL_CHECK_EN.
module ex6_out_monitor #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     y1,
  input  logic                     y2,
  input  logic                     y3,
  input  logic                     y4,
  input  logic                     y5,
  input  logic                     y6,
  input  logic                     y7,
  input  logic                     y8,
  input  logic                     flush,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_word,
  output logic [LEN_W-1:0]         out_len,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [DROP_W-1:0]        drop_cnt,
  output logic                     overflow,
  output logic                     illegal
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned RecW = 8 + LEN_W;
  localparam logic [LEN_W-1:0]  LenMax  = {LEN_W{1'b1}};
  localparam logic [DROP_W-1:0] DropMax = {DROP_W{1'b1}};

  typedef enum logic {StUnprimed, StTrack} state_e;

  logic [7:0] w;
  assign w = {y8, y7, y6, y5, y4, y3, y2, y1};

  state_e             state_q, state_d;
  logic [7:0]         prev_q, prev_d;
  logic [LEN_W-1:0]   run_q, run_d;
  logic               push;

  logic [RecW-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  logic [DROP_W-1:0]  drop_q;
  logic               ovf_q;
  logic               full, pop, wr_en, drop;

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    run_d   = run_q;
    push    = 1'b0;
    unique case (state_q)
      StUnprimed: begin
        prev_d  = w;
        run_d   = LEN_W'(1);
        state_d = StTrack;
      end
      StTrack: begin
        // A change and a flush on the same edge close the run only once.
        if ((w != prev_q) || flush) begin
          push   = 1'b1;
          prev_d = w;
          run_d  = LEN_W'(1);
        end else if (run_q != LenMax) begin
          run_d = run_q + LEN_W'(1);
        end
      end
    endcase
  end

  assign full  = (count_q == CntW'(DEPTH));
  assign pop   = out_valid && out_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StUnprimed;
      prev_q   <= '0;
      run_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      run_q   <= run_d;
      count_q <= count_d;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != DropMax) begin
          drop_q <= drop_q + DROP_W'(1);
        end
      end
    end
  end

  // Storage needs no reset: occupancy gates everything read from it.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      mem_q[wr_ptr_q] <= {prev_q, run_q};
    end
  end

  assign out_valid  = (count_q != '0);
  assign out_word   = out_valid ? mem_q[rd_ptr_q][RecW-1:LEN_W] : 8'h00;
  assign out_len    = out_valid ? mem_q[rd_ptr_q][LEN_W-1:0] : '0;
  assign fifo_count = count_q;
  assign drop_cnt   = drop_q;
  assign overflow   = ovf_q;

`ifdef EX6MON_LEGAL_CHECK_EN
  logic illegal_q;
  logic w_legal;

  always_comb begin
    w_legal = 1'b0;
    case (w)
      8'h00, 8'h03, 8'h0B, 8'h14, 8'h1C, 8'h1D, 8'h21,
      8'h70, 8'h83, 8'h94, 8'h9D, 8'hA4, 8'hAC: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      illegal_q <= 1'b0;
    end else if (!w_legal) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_ex6_out_monitor.sv
// Directed bench for ex6_out_monitor: queue-based record model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_ex6_out_monitor;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LEN_W = 8;
  localparam int unsigned DROP_W = 8;
  localparam int LenMax = (1 << LEN_W) - 1;
  localparam int DropMax = (1 << DROP_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic y1, y2, y3, y4, y5, y6, y7, y8;
  logic flush = 1'b0;
  logic out_ready = 1'b0;
  logic out_valid;
  logic [7:0] out_word;
  logic [LEN_W-1:0] out_len;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [DROP_W-1:0] drop_cnt;
  logic overflow;
  logic illegal;

  ex6_out_monitor #(
    .DEPTH (DEPTH),
    .LEN_W (LEN_W),
    .DROP_W(DROP_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .y4        (y4),
    .y5        (y5),
    .y6        (y6),
    .y7        (y7),
    .y8        (y8),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_word  (out_word),
    .out_len   (out_len),
    .fifo_count(fifo_count),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] word;
    logic [7:0] len;
  } rec_t;

  rec_t mq[$];
  bit   m_primed = 0;
  logic [7:0] m_prev = 8'h00;
  int   m_run = 0;
  int   m_drop = 0;
  bit   m_ovf = 0;
  bit   m_ill = 0;
  bit   chk_en = 0;

  int checks = 0;
  int errors = 0;

  logic [7:0] legal_set [13] = '{8'h00, 8'h03, 8'h0B, 8'h14, 8'h1C, 8'h1D, 8'h21,
                                 8'h70, 8'h83, 8'h94, 8'h9D, 8'hA4, 8'hAC};

  function automatic bit is_legal(input logic [7:0] v);
    for (int i = 0; i < 13; i++) begin
      if (legal_set[i] == v) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Record-level view: a run closes on change or flush, the FIFO holds at most DEPTH records.
  task automatic model_update(input logic [7:0] wv, input bit fl, input bit rd, input bit rs);
    bit   popped;
    bit   was_full;
    bit   have_push;
    rec_t rec;
    if (!rs) begin
      mq.delete();
      m_primed = 0;
      m_prev = 8'h00;
      m_run = 0;
      m_drop = 0;
      m_ovf = 0;
      m_ill = 0;
      return;
    end
    popped = (mq.size() != 0) && rd;
    was_full = (mq.size() == DEPTH);
    have_push = 0;
    rec = '0;
`ifdef EX6MON_LEGAL_CHECK_EN
    if (!is_legal(wv)) m_ill = 1;
`endif
    if (!m_primed) begin
      m_primed = 1;
      m_prev = wv;
      m_run = 1;
    end else if (wv != m_prev || fl) begin
      rec.word = m_prev;
      rec.len = 8'(m_run);
      have_push = 1;
      m_prev = wv;
      m_run = 1;
    end else if (m_run < LenMax) begin
      m_run++;
    end
    if (popped) void'(mq.pop_front());
    if (have_push) begin
      if (!was_full || popped) begin
        mq.push_back(rec);
      end else begin
        if (m_drop < DropMax) m_drop++;
        m_ovf = 1;
      end
    end
  endtask

  task automatic step(input logic [7:0] wv, input bit fl, input bit rd, input bit rs);
    {y8, y7, y6, y5, y4, y3, y2, y1} = wv;
    flush = fl;
    out_ready = rd;
    rst = rs;
    @(posedge clk);
    model_update(wv, fl, rd, rs);
    @(negedge clk);
  endtask

  task automatic hold(input logic [7:0] wv, input bit rd, input int n);
    for (int i = 0; i < n; i++) step(wv, 1'b0, rd, 1'b1);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("model_word", 32'(out_word), 32'(mq[0].word));
        chk("model_len", 32'(out_len), 32'(mq[0].len));
      end
      chk("model_count", 32'(fifo_count), 32'(mq.size()));
      chk("model_drop", 32'(drop_cnt), 32'(m_drop));
      chk("model_ovf", 32'(overflow), 32'(m_ovf));
      chk("model_illegal", 32'(illegal), 32'(m_ill));
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_word"}, 32'(out_word), 32'd0);
    chk({tag, "_len"}, 32'(out_len), 32'd0);
    chk({tag, "_count"}, 32'(fifo_count), 32'd0);
    chk({tag, "_drop"}, 32'(drop_cnt), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_illegal"}, 32'(illegal), 32'd0);
  endtask

  initial begin
    {y8, y7, y6, y5, y4, y3, y2, y1} = 8'h00;
    @(negedge clk);
    step(8'h00, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0);
    check_reset_state("reset");
    chk_en = 1;

    // 1: ten edges of 0x1D, then 0x14 closes the run.
    hold(8'h1D, 1'b1, 10);
    chk("t1_no_early_record", 32'(out_valid), 32'd0);
    step(8'h14, 1'b0, 1'b1, 1'b1);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_word", 32'(out_word), 32'h1D);
    chk("t1_len", 32'(out_len), 32'd10);
    step(8'h14, 1'b0, 1'b1, 1'b1);
    chk("t1_popped", 32'(out_valid), 32'd0);

    // 2: a 300-cycle run saturates at 255.
    hold(8'h03, 1'b1, 300);
    step(8'h0B, 1'b0, 1'b0, 1'b1);
    chk("t2_word", 32'(out_word), 32'h03);
    chk("t2_len_sat", 32'(out_len), 32'd255);
    step(8'h0B, 1'b0, 1'b1, 1'b1);
    chk("t2_drained", 32'(fifo_count), 32'd0);

    // 3: six records into a 4-deep FIFO with no consumer.
    step(8'h14, 1'b0, 1'b0, 1'b1);
    step(8'h1C, 1'b0, 1'b0, 1'b1);
    step(8'h21, 1'b0, 1'b0, 1'b1);
    step(8'h70, 1'b0, 1'b0, 1'b1);
    step(8'h83, 1'b0, 1'b0, 1'b1);
    step(8'h94, 1'b0, 1'b0, 1'b1);
    chk("t3_count", 32'(fifo_count), 32'd4);
    chk("t3_drop", 32'(drop_cnt), 32'd2);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_head_word", 32'(out_word), 32'h0B);
    chk("t3_head_len", 32'(out_len), 32'd2);

    // 4: push while full with a simultaneous pop.
    step(8'h9D, 1'b0, 1'b1, 1'b1);
    chk("t4_count", 32'(fifo_count), 32'd4);
    chk("t4_drop", 32'(drop_cnt), 32'd2);
    chk("t4_head", 32'(out_word), 32'h14);
    hold(8'h9D, 1'b1, 3);
    chk("t4_newest_last", 32'(out_word), 32'h94);
    chk("t4_last_count", 32'(fifo_count), 32'd1);
    step(8'h9D, 1'b0, 1'b1, 1'b1);
    chk("t4_empty", 32'(out_valid), 32'd0);
    chk("t4_ovf_sticky", 32'(overflow), 32'd1);

    // 5: flush splits a run; flush with a change yields one record.
    hold(8'h21, 1'b0, 5);
    step(8'h21, 1'b1, 1'b0, 1'b1);
    hold(8'h21, 1'b0, 2);
    step(8'h94, 1'b0, 1'b0, 1'b1);
    chk("t5_count3", 32'(fifo_count), 32'd3);
    step(8'hA4, 1'b1, 1'b0, 1'b1);
    chk("t5_single_push", 32'(fifo_count), 32'd4);
    chk("t5_drop_same", 32'(drop_cnt), 32'd2);
    chk("t5_rec0", 32'({out_word, out_len}), 32'h9D05);
    step(8'hA4, 1'b0, 1'b1, 1'b1);
    chk("t5_rec1", 32'({out_word, out_len}), 32'h2105);
    step(8'hA4, 1'b0, 1'b1, 1'b1);
    chk("t5_rec2", 32'({out_word, out_len}), 32'h2103);
    step(8'hA4, 1'b0, 1'b1, 1'b1);
    chk("t5_rec3", 32'({out_word, out_len}), 32'h9401);
    step(8'hA4, 1'b0, 1'b1, 1'b1);
    chk("t5_empty", 32'(out_valid), 32'd0);

    // 6: reset mid-operation, then an illegal word.
    step(8'hAC, 1'b0, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    step(8'h03, 1'b0, 1'b0, 1'b1);
    chk("t6_queued", 32'(fifo_count), 32'd3);
    step(8'h03, 1'b0, 1'b0, 1'b0);
    check_reset_state("t6_reset");
    step(8'hFF, 1'b0, 1'b0, 1'b1);
`ifdef EX6MON_LEGAL_CHECK_EN
    chk("t6_illegal_set", 32'(illegal), 32'd1);
`else
    chk("t6_illegal_off", 32'(illegal), 32'd0);
`endif
    hold(8'hFF, 1'b0, 2);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    chk("t6_ff_rec", 32'({out_word, out_len}), 32'hFF03);
`ifdef EX6MON_LEGAL_CHECK_EN
    chk("t6_illegal_sticky", 32'(illegal), 32'd1);
`else
    chk("t6_illegal_still_off", 32'(illegal), 32'd0);
`endif
    hold(8'h00, 1'b1, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
